// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready code converter: pass-through, binary->Gray, Gray->binary, negate.
// Optional macro CODE_CONV_ERRCNT_EN adds an 8-bit saturating count of flagged output words.
module code_conv_pipe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
`ifdef CODE_CONV_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam logic [W-1:0] W_MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         r_s1_valid;
    logic [W-1:0] r_s1_data;
    logic [1:0]   r_s1_mode;
    logic         r_s2_valid;
    logic [W-1:0] r_s2_data;
    logic         r_s2_err;

    logic         w_s1_adv;
    logic         w_in_xfer;
    logic [W-1:0] w_res;
    logic         w_err;

    // Stage 1 moves into stage 2 when stage 2 is empty or draining this cycle.
    assign w_s1_adv  = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~rst & (~r_s1_valid | w_s1_adv);
    assign w_in_xfer = in_valid & in_ready;

    always_comb begin
        w_res = r_s1_data;
        w_err = 1'b0;
        case (r_s1_mode)
            2'b00: w_res = r_s1_data;
            2'b01: w_res = r_s1_data ^ (r_s1_data >> 1);
            2'b10: begin
                for (int k = 0; k < W; k++) begin
                    w_res[k] = ^(r_s1_data >> k);
                end
            end
            default: begin
                w_res = ~r_s1_data + 1'b1;
                w_err = (r_s1_data == W_MIN_NEG);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 2'b00;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_mode  <= mode;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= w_res;
                r_s2_err   <= w_err;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_err   = r_s2_err;

`ifdef CODE_CONV_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (r_s2_valid && out_ready && r_s2_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_code_conv_pipe.sv
// Self-checking bench for code_conv_pipe: vector table, hand sequences, random traffic vs. model.
// Define CODE_CONV_ERRCNT_EN to also exercise the error counter.
module tb_code_conv_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
`ifdef CODE_CONV_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    logic [W:0] q_exp[$];

    always #5 clk = ~clk;

    code_conv_pipe #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
`ifdef CODE_CONV_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions; returns {err, data}.
    function automatic logic [W:0] ref_conv(input logic [W-1:0] d, input logic [1:0] m);
        int v;
        int r;
        int e;
        int b;
        v = int'(d);
        r = 0;
        e = 0;
        case (m)
            2'd0: r = v;
            2'd1: r = v ^ (v / 2);
            2'd2: begin
                for (int k = 0; k < W; k++) begin
                    b = 0;
                    for (int j = k; j < W; j++) b = b ^ ((v >> j) & 1);
                    r = r + (b << k);
                end
            end
            default: begin
                r = ((1 << W) - v) % (1 << W);
                e = (v == (1 << (W - 1))) ? 1 : 0;
            end
        endcase
        return {e[0], r[W-1:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_err;
    logic [W:0]   exp_item;

    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
                chk("stall_err", int'(out_err), int'(prev_err));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q_exp.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_item = q_exp.pop_front();
                    chk("sb_data", int'(out_data), int'(exp_item[W-1:0]));
                    chk("sb_err", int'(out_err), int'(exp_item[W]));
                end
            end
            if (in_valid && in_ready) q_exp.push_back(ref_conv(in_data, mode));
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
        end
    end

    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] d;
        logic [W-1:0] exp_d;
        logic         exp_e;
    } vec_t;

    vec_t tbl[$];

    task automatic drain(input string name);
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q_exp.size() != 0 || out_valid) && guard < 50) begin
            cyc();
            guard++;
        end
        chk(name, q_exp.size(), 0);
    endtask

    initial begin
        logic [W-1:0] gray_exp[16];
        logic [W-1:0] bp_words[5];
        int           bp_idx;
        int           n_out_base;
        int           guard;

        gray_exp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        for (int i = 0; i < 16; i++) tbl.push_back('{2'b01, 4'(i), gray_exp[i], 1'b0});
        tbl.push_back('{2'b10, 4'b1101, 4'b1001, 1'b0});
        tbl.push_back('{2'b11, 4'b1000, 4'b1000, 1'b1});
        tbl.push_back('{2'b11, 4'b0011, 4'b1101, 1'b0});
        tbl.push_back('{2'b00, 4'b1010, 4'b1010, 1'b0});
        tbl.push_back('{2'b11, 4'b0001, 4'b1111, 1'b0});
        tbl.push_back('{2'b11, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{2'b10, 4'b1000, 4'b1111, 1'b0});

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00; out_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("in_ready_in_rst", int'(in_ready), 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Back-to-back table stream at out_ready=1: entry c shows up two cycles later.
        out_ready = 1'b1;
        for (int c = 0; c < tbl.size() + 2; c++) begin
            cyc();
            if (c < tbl.size()) begin
                in_valid = 1'b1; in_data = tbl[c].d; mode = tbl[c].m;
            end else begin
                in_valid = 1'b0; in_data = 4'hF; mode = 2'b11;
            end
            @(negedge clk);
            if (c < tbl.size()) chk("tbl_in_ready", int'(in_ready), 1);
            if (c >= 2) begin
                chk("tbl_valid", int'(out_valid), 1);
                chk("tbl_data", int'(out_data), int'(tbl[c-2].exp_d));
                chk("tbl_err", int'(out_err), int'(tbl[c-2].exp_e));
            end
        end
        drain("tbl_drain");

        // Backpressure: out_ready low for cycles 2..4 of a 5-word stream.
        bp_words = '{4'd3, 4'd9, 4'd12, 4'd5, 4'd14};
        bp_idx = 0;
        n_out_base = n_out;
        guard = 0;
        while ((bp_idx < 5) && guard < 40) begin
            cyc();
            out_ready = !(guard >= 2 && guard <= 4);
            in_valid  = 1'b1;
            in_data   = bp_words[bp_idx];
            mode      = 2'(bp_idx % 4);
            @(negedge clk);
            if (guard >= 2 && guard <= 4) chk("bp_in_ready_low", int'(in_ready), 0);
            if (in_valid && in_ready) bp_idx++;
            guard++;
        end
        chk("bp_all_accepted", bp_idx, 5);
        cyc();
        drain("bp_drain");
        chk("bp_out_count", n_out - n_out_base, 5);

        // Reset with two words in flight.
        cyc();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd6; mode = 2'b01;
        cyc();
        in_data = 4'd7;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight_full", int'(in_ready), 0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        n_out_base = n_out;
        out_ready = 1'b1;
        repeat (10) cyc();
        chk("no_stale_words", n_out - n_out_base, 0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cyc();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            mode      = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain("rand_drain");

`ifdef CODE_CONV_ERRCNT_EN
        bp_idx = 0;
        guard = 0;
        out_ready = 1'b1;
        while (bp_idx < 300 && guard < 400) begin
            cyc();
            in_valid = 1'b1; in_data = 4'b1000; mode = 2'b11;
            @(negedge clk);
            if (in_ready) bp_idx++;
            guard++;
        end
        chk("errcnt_words", bp_idx, 300);
        cyc();
        drain("errcnt_drain");
        chk("errcnt_sat", int'(err_cnt), 255);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("errcnt_rst", int'(err_cnt), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
